mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32: PC and memory-address width, legal range 8..32.
REQ-002 SHALL provide parameter RESET_PC, default 0: PC value loaded on reset, word-aligned.
REQ-003 SHALL provide parameter WAIT_MAX, default 255: maximum consecutive mem_ready-low cycles tolerated in FETCH/MEM, legal range 1..255.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 mem_rdata  in  32  instruction/data word from memory.
REQ-008 mem_ready  in  1  memory transfer completes this cycle.
REQ-009 rs_data  in  ADDR_W  register-file ReadData1 low bits, used as the JR target.
REQ-010 alu_zero  in  1  ALU zero flag.
REQ-011 pc  out  ADDR_W  program counter.
REQ-012 ir  out  32  instruction register.
REQ-013 mem_req / mem_we  out  1 each  memory request and write strobe.
REQ-014 mem_addr_sel  out  1  address select: 0 = pc, 1 = ALU result.
REQ-015 reg_we  out  1; reg_dst  out  2: 0 = rt, 1 = rd, 2 = r31.
REQ-016 wb_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = pc.
REQ-017 alu_src  out  1 (0 = ReadData2, 1 = sign-extended imm16); alu_cntrl  out  3.
REQ-018 state_o  out  3: current state; bus_err / illegal  out  1 each: sticky error flags.

Function
REQ-019 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7; all outputs are Moore functions of state and ir.
REQ-020 ALU encoding SHALL be: ADD 000, SUB 001, XOR 010, SLT 011, AND 100, NAND 101, NOR 110, OR 111.
REQ-021 FETCH SHALL drive mem_req=1, mem_addr_sel=0; when mem_ready=1: ir <= mem_rdata, pc <= pc+4 (mod 2^ADDR_W), next state DECODE; otherwise remain in FETCH.
REQ-022 DECODE SHALL last one cycle and dispatch on opcode:
- R-type 0x00 (funct 0x20/22/24/25/26/27/2A), ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05 -> EXEC.
- J 0x02: pc <= target26<<2, with pc[ADDR_W-1:28] kept when ADDR_W>28 -> FETCH.
- JAL 0x03: same pc update, plus reg_we=1, reg_dst=2, wb_sel=2 (old pc+4 written) -> FETCH.
- JR (R-type, funct 0x08): pc <= rs_data -> FETCH.
- Any other opcode/funct: illegal <= 1 -> ERROR.
REQ-023 EXEC SHALL drive alu_cntrl per funct (R-type), ADD (ADDI/LW/SW) or SUB (BEQ/BNE), and alu_src=1 for ADDI/LW/SW.
REQ-024 EXEC exits: R-type/ADDI -> WB; LW/SW -> MEM; BEQ/BNE -> FETCH, with pc <= pc + (sext(imm16)<<2), truncated to ADDR_W, when taken (BEQ: alu_zero=1; BNE: alu_zero=0).
REQ-025 MEM SHALL drive mem_req=1, mem_addr_sel=1, alu_src=1, alu_cntrl=ADD, mem_we=1 for SW only; on mem_ready, SW -> FETCH and LW -> WB.
REQ-026 WB SHALL hold EXEC's ALU controls and assert reg_we=1 for exactly one cycle: R-type reg_dst=1, wb_sel=0; ADDI reg_dst=0, wb_sel=0; LW reg_dst=0, wb_sel=1; next state FETCH.
REQ-027 A wait counter SHALL clear on entry to FETCH/MEM and increment on each cycle with mem_req=1 and mem_ready=0; reaching WAIT_MAX sets bus_err <= 1 and moves to ERROR.
REQ-028 ERROR SHALL be terminal until reset: all strobes 0, pc/ir frozen.
REQ-029 mem_ready outside FETCH/MEM SHALL be ignored; mem_we SHALL never be 1 while mem_req=0.

Reset
REQ-030 While reset=1: state FETCH, pc=RESET_PC, ir=0, counter 0, bus_err=0, illegal=0, and all strobes (mem_req, mem_we, reg_we) forced to 0 asynchronously, including mid-transfer.
REQ-031 The first rising clk edge after reset falls SHALL see FETCH with mem_req=1.

Verification
REQ-032 Reset mid-MEM wait -> strobes 0 immediately; after release, pc=RESET_PC, state_o=0, mem_req=1.
REQ-033 ADD 0x00221820, mem_ready always 1 -> states 0,1,2,4,0; in WB reg_we=1, reg_dst=1, alu_cntrl=000; pc advances by 4.
REQ-034 LW 0x8C220004, mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles, mem_we=0, mem_addr_sel=1; then WB with reg_dst=0, wb_sel=1.
REQ-035 BEQ 0x1000FFFF fetched at pc=0x10 -> alu_zero=1 gives pc=0x10, alu_zero=0 gives pc=0x14; BNE gives the inverse.
REQ-036 WAIT_MAX=4, mem_ready held 0 in FETCH -> ERROR after 4 wait cycles, bus_err=1 until reset; SW never asserts mem_we outside MEM.
REQ-037 JAL 0x0C000040 at pc=0 -> DECODE asserts reg_we, reg_dst=2, wb_sel=2, then pc=0x100; opcode 0x3F -> illegal=1, state_o=7.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// PC/IR ownership, memory handshake with wait timeout and sticky error flags.
module mc_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_addr_sel,
    output logic              reg_we,
    output logic [1:0]        reg_dst,
    output logic [1:0]        wb_sel,
    output logic              alu_src,
    output logic [2:0]        alu_cntrl,
    output logic [2:0]        state_o,
    output logic              bus_err,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_NAND = 3'b101,
        ALU_NOR  = 3'b110,
        ALU_OR   = 3'b111
    } alu_op_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_BAD
    } iclass_t;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t            state, state_next;
    iclass_t           iclass;
    alu_op_t           rtype_op, exec_alu;
    logic              exec_src;
    logic [ADDR_W-1:0] pc_next, pc_plus4, jump_pc, branch_pc;
    logic [31:0]       ir_next, pc_wide, jump_wide, branch_off;
    logic [7:0]        wait_cnt, wait_next, wait_inc;
    logic              bus_err_next, illegal_next, branch_taken;
    logic              req, we, rwe;

    logic [5:0] opcode, funct;
    assign opcode = ir[31:26];
    assign funct  = ir[5:0];

    // Instruction classification; anything not listed is illegal.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        iclass   = C_BAD;
        rtype_op = ALU_ADD;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: begin iclass = C_RTYPE; rtype_op = ALU_ADD; end
                    6'h22: begin iclass = C_RTYPE; rtype_op = ALU_SUB; end
                    6'h24: begin iclass = C_RTYPE; rtype_op = ALU_AND; end
                    6'h25: begin iclass = C_RTYPE; rtype_op = ALU_OR;  end
                    6'h26: begin iclass = C_RTYPE; rtype_op = ALU_XOR; end
                    6'h27: begin iclass = C_RTYPE; rtype_op = ALU_NOR; end
                    6'h2A: begin iclass = C_RTYPE; rtype_op = ALU_SLT; end
                    6'h08: iclass = C_JR;
                    default: iclass = C_BAD;
                endcase
            end
            6'h08:   iclass = C_ADDI;
            6'h23:   iclass = C_LW;
            6'h2B:   iclass = C_SW;
            6'h04:   iclass = C_BEQ;
            6'h05:   iclass = C_BNE;
            6'h02:   iclass = C_J;
            6'h03:   iclass = C_JAL;
            default: iclass = C_BAD;
        endcase
    end

    // ALU controls shared by EXEC and WB.
    always_comb begin
        exec_alu = ALU_ADD;
        exec_src = 1'b0;
        case (iclass)
            C_RTYPE:            exec_alu = rtype_op;
            C_ADDI, C_LW, C_SW: exec_src = 1'b1;
            C_BEQ, C_BNE:       exec_alu = ALU_SUB;
            default:            exec_alu = ALU_ADD;
        endcase
    end

    assign pc_plus4   = pc + ADDR_W'(4);
    assign pc_wide    = 32'(pc);
    assign jump_wide  = (pc_wide & 32'hF000_0000) | {4'b0000, ir[25:0], 2'b00};
    assign jump_pc    = jump_wide[ADDR_W-1:0];
    assign branch_off = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign branch_pc  = pc + branch_off[ADDR_W-1:0];
    assign wait_inc   = wait_cnt + 8'd1;

    assign branch_taken = ((iclass == C_BEQ) && alu_zero) ||
                          ((iclass == C_BNE) && !alu_zero);

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        ir_next      = ir;
        wait_next    = '0;
        bus_err_next = bus_err;
        illegal_next = illegal;
        req          = 1'b0;
        we           = 1'b0;
        rwe          = 1'b0;
        mem_addr_sel = 1'b0;
        reg_dst      = 2'd0;
        wb_sel       = 2'd0;
        alu_src      = 1'b0;
        alu_cntrl    = ALU_ADD;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc_plus4;
                    state_next = S_DECODE;
                end else if (wait_inc == WAIT_LIM) begin
                    bus_err_next = 1'b1;
                    state_next   = S_ERROR;
                end else begin
                    wait_next = wait_inc;
                end
            end
            S_DECODE: begin
                case (iclass)
                    C_J: begin
                        pc_next    = jump_pc;
                        state_next = S_FETCH;
                    end
                    C_JAL: begin
                        // pc already holds the link address (old pc + 4) here.
                        pc_next    = jump_pc;
                        rwe        = 1'b1;
                        reg_dst    = 2'd2;
                        wb_sel     = 2'd2;
                        state_next = S_FETCH;
                    end
                    C_JR: begin
                        pc_next    = rs_data;
                        state_next = S_FETCH;
                    end
                    C_BAD: begin
                        illegal_next = 1'b1;
                        state_next   = S_ERROR;
                    end
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_cntrl = exec_alu;
                alu_src   = exec_src;
                case (iclass)
                    C_RTYPE, C_ADDI: state_next = S_WB;
                    C_LW, C_SW:      state_next = S_MEM;
                    default: begin
                        if (branch_taken) pc_next = branch_pc;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                req          = 1'b1;
                we           = (iclass == C_SW);
                mem_addr_sel = 1'b1;
                alu_src      = 1'b1;
                alu_cntrl    = ALU_ADD;
                if (mem_ready) begin
                    state_next = (iclass == C_SW) ? S_FETCH : S_WB;
                end else if (wait_inc == WAIT_LIM) begin
                    bus_err_next = 1'b1;
                    state_next   = S_ERROR;
                end else begin
                    wait_next = wait_inc;
                end
            end
            S_WB: begin
                alu_cntrl  = exec_alu;
                alu_src    = exec_src;
                rwe        = 1'b1;
                reg_dst    = (iclass == C_RTYPE) ? 2'd1 : 2'd0;
                wb_sel     = (iclass == C_LW)    ? 2'd1 : 2'd0;
                state_next = S_FETCH;
            end
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ERROR;
        endcase
    end

    // Strobes drop the instant reset rises, even mid-transfer.
    assign mem_req = req & ~reset;
    assign mem_we  = we  & ~reset;
    assign reg_we  = rwe & ~reset;
    assign state_o = state;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC[ADDR_W-1:0];
            ir       <= '0;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            pc       <= pc_next;
            ir       <= ir_next;
            wait_cnt <= wait_next;
            bus_err  <= bus_err_next;
            illegal  <= illegal_next;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: expectations are queued with each stimulus step
// and drained against the DUT outputs one cycle later.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] rs_data;
    logic        alu_zero;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        mem_req, mem_we, mem_addr_sel, reg_we, alu_src, bus_err, illegal;
    logic [1:0]  reg_dst, wb_sel;
    logic [2:0]  alu_cntrl, state_o;

    mc_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rs_data(rs_data), .alu_zero(alu_zero), .pc(pc), .ir(ir),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src(alu_src),
        .alu_cntrl(alu_cntrl), .state_o(state_o), .bus_err(bus_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum {
        SIG_STATE, SIG_PC, SIG_IR, SIG_REQ, SIG_WE, SIG_ASEL, SIG_RWE,
        SIG_RDST, SIG_WBSEL, SIG_ASRC, SIG_ALU, SIG_BERR, SIG_ILL
    } sig_t;

    typedef struct {
        string       tag;
        sig_t        sig;
        logic [31:0] val;
    } exp_t;

    exp_t  sb[$];
    string phase = "init";
    int    checks = 0;
    int    failures = 0;

    function automatic logic [31:0] probe(input sig_t s);
        case (s)
            SIG_STATE: return 32'(state_o);
            SIG_PC:    return pc;
            SIG_IR:    return ir;
            SIG_REQ:   return 32'(mem_req);
            SIG_WE:    return 32'(mem_we);
            SIG_ASEL:  return 32'(mem_addr_sel);
            SIG_RWE:   return 32'(reg_we);
            SIG_RDST:  return 32'(reg_dst);
            SIG_WBSEL: return 32'(wb_sel);
            SIG_ASRC:  return 32'(alu_src);
            SIG_ALU:   return 32'(alu_cntrl);
            SIG_BERR:  return 32'(bus_err);
            default:   return 32'(illegal);
        endcase
    endfunction

    task automatic push_exp(input sig_t s, input logic [31:0] v);
        exp_t e;
        e.tag = {phase, ".", s.name()};
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    // Drain every queued expectation against the current outputs.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = probe(e.sig);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic run_branch(input logic [31:0] instr, input logic zero,
                              input logic [31:0] exp_pc);
        mem_rdata = instr;
        mem_ready = 1'b1;
        step();
        step();
        push_exp(SIG_STATE, 2); push_exp(SIG_ALU, 3'b001); push_exp(SIG_ASRC, 0);
        check();
        alu_zero = zero;
        step();
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, exp_pc);
        check();
    endtask

    logic [5:0] functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    logic [2:0] alus   [7] = '{3'b000, 3'b001, 3'b100, 3'b111, 3'b010, 3'b110, 3'b011};

    initial begin
        reset = 1'b0; mem_rdata = '0; mem_ready = 1'b0; rs_data = '0; alu_zero = 1'b0;
        #1 reset = 1'b1;
        #1;
        phase = "reset";
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, 0); push_exp(SIG_IR, 0);
        push_exp(SIG_REQ, 0); push_exp(SIG_WE, 0); push_exp(SIG_RWE, 0);
        push_exp(SIG_BERR, 0); push_exp(SIG_ILL, 0);
        check();
        step(); step();
        reset = 1'b0;
        #1;
        phase = "release";
        push_exp(SIG_STATE, 0); push_exp(SIG_REQ, 1); push_exp(SIG_ASEL, 0); push_exp(SIG_PC, 0);
        check();

        phase = "add";
        mem_rdata = 32'h0022_1820; mem_ready = 1'b1;
        step();
        push_exp(SIG_STATE, 1); push_exp(SIG_IR, 32'h0022_1820); push_exp(SIG_PC, 4); push_exp(SIG_REQ, 0);
        check();
        step();
        push_exp(SIG_STATE, 2); push_exp(SIG_ALU, 0); push_exp(SIG_ASRC, 0); push_exp(SIG_RWE, 0);
        check();
        step();
        push_exp(SIG_STATE, 4); push_exp(SIG_RWE, 1); push_exp(SIG_RDST, 1);
        push_exp(SIG_WBSEL, 0); push_exp(SIG_ALU, 0);
        check();
        step();
        push_exp(SIG_STATE, 0); push_exp(SIG_RWE, 0); push_exp(SIG_PC, 4); push_exp(SIG_REQ, 1);
        check();

        for (int i = 0; i < 7; i++) begin
            phase = $sformatf("rtype%0d", i);
            mem_rdata = 32'h0022_1800 | 32'(functs[i]);
            step();
            step();
            push_exp(SIG_STATE, 2); push_exp(SIG_ALU, 32'(alus[i]));
            check();
            step();
            push_exp(SIG_STATE, 4); push_exp(SIG_ALU, 32'(alus[i])); push_exp(SIG_RWE, 1); push_exp(SIG_RDST, 1);
            check();
            step();
        end
        phase = "rtype_pc";
        push_exp(SIG_PC, 32'h20);
        check();

        phase = "addi";
        mem_rdata = 32'h2022_0005;
        step();
        step();
        push_exp(SIG_STATE, 2); push_exp(SIG_ASRC, 1); push_exp(SIG_ALU, 0);
        check();
        step();
        push_exp(SIG_STATE, 4); push_exp(SIG_RWE, 1); push_exp(SIG_RDST, 0);
        push_exp(SIG_WBSEL, 0); push_exp(SIG_ASRC, 1);
        check();
        step();

        phase = "jr";
        mem_rdata = 32'h0020_0008; rs_data = 32'h10;
        step();
        push_exp(SIG_PC, 32'h28); push_exp(SIG_STATE, 1);
        check();
        step();
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, 32'h10); push_exp(SIG_RWE, 0);
        check();

        phase = "beq_taken";     run_branch(32'h1000_FFFF, 1'b1, 32'h10);
        phase = "beq_not_taken"; run_branch(32'h1000_FFFF, 1'b0, 32'h14);
        phase = "bne_taken";     run_branch(32'h1400_FFFF, 1'b0, 32'h14);
        phase = "bne_not_taken"; run_branch(32'h1400_FFFF, 1'b1, 32'h18);

        phase = "lw";
        mem_rdata = 32'h8C22_0004; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        push_exp(SIG_STATE, 2); push_exp(SIG_ASRC, 1); push_exp(SIG_ALU, 0); push_exp(SIG_REQ, 0);
        check();
        step();
        push_exp(SIG_STATE, 3); push_exp(SIG_REQ, 1); push_exp(SIG_WE, 0);
        push_exp(SIG_ASEL, 1); push_exp(SIG_ASRC, 1);
        check();
        for (int i = 0; i < 3; i++) begin
            step();
            push_exp(SIG_STATE, 3); push_exp(SIG_WE, 0); push_exp(SIG_ASEL, 1);
            check();
        end
        mem_ready = 1'b1;
        step();
        push_exp(SIG_STATE, 4); push_exp(SIG_RWE, 1); push_exp(SIG_RDST, 0); push_exp(SIG_WBSEL, 1);
        check();
        step();
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, 32'h1C); push_exp(SIG_RWE, 0);
        check();

        phase = "sw";
        mem_rdata = 32'hAC22_0004;
        step();
        push_exp(SIG_STATE, 1); push_exp(SIG_WE, 0); push_exp(SIG_REQ, 0);
        check();
        step();
        push_exp(SIG_STATE, 2); push_exp(SIG_WE, 0); push_exp(SIG_REQ, 0); push_exp(SIG_ASRC, 1);
        check();
        step();
        push_exp(SIG_STATE, 3); push_exp(SIG_WE, 1); push_exp(SIG_REQ, 1); push_exp(SIG_ASEL, 1);
        check();
        step();
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, 32'h20); push_exp(SIG_WE, 0);
        push_exp(SIG_ASEL, 0); push_exp(SIG_RWE, 0);
        check();

        phase = "reset_mid_mem";
        mem_rdata = 32'h8C22_0004;
        step();
        mem_ready = 1'b0;
        step();
        step();
        step();
        push_exp(SIG_STATE, 3); push_exp(SIG_REQ, 1);
        check();
        reset = 1'b1;
        #1;
        push_exp(SIG_REQ, 0); push_exp(SIG_WE, 0); push_exp(SIG_RWE, 0);
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, 0); push_exp(SIG_IR, 0);
        check();
        step();
        reset = 1'b0;
        #1;
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, 0); push_exp(SIG_REQ, 1);
        check();

        phase = "jal";
        mem_rdata = 32'h0C00_0040; mem_ready = 1'b1;
        step();
        push_exp(SIG_STATE, 1); push_exp(SIG_RWE, 1); push_exp(SIG_RDST, 2);
        push_exp(SIG_WBSEL, 2); push_exp(SIG_PC, 4);
        check();
        step();
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, 32'h100); push_exp(SIG_RWE, 0);
        check();

        phase = "j";
        mem_rdata = 32'h0800_0004;
        step();
        push_exp(SIG_RWE, 0);
        check();
        step();
        push_exp(SIG_STATE, 0); push_exp(SIG_PC, 32'h10);
        check();

        phase = "bus_err";
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            push_exp(SIG_STATE, 0); push_exp(SIG_REQ, 1); push_exp(SIG_BERR, 0);
            check();
        end
        step();
        push_exp(SIG_STATE, 7); push_exp(SIG_BERR, 1); push_exp(SIG_REQ, 0); push_exp(SIG_ILL, 0);
        check();
        mem_ready = 1'b1;
        step();
        step();
        push_exp(SIG_STATE, 7); push_exp(SIG_PC, 32'h10); push_exp(SIG_BERR, 1);
        push_exp(SIG_REQ, 0); push_exp(SIG_WE, 0);
        check();

        phase = "illegal_op";
        do_reset();
        push_exp(SIG_BERR, 0); push_exp(SIG_STATE, 0);
        check();
        mem_rdata = 32'hFC00_0000;
        step();
        step();
        push_exp(SIG_STATE, 7); push_exp(SIG_ILL, 1); push_exp(SIG_BERR, 0);
        push_exp(SIG_PC, 4); push_exp(SIG_REQ, 0);
        check();
        step();
        push_exp(SIG_STATE, 7); push_exp(SIG_IR, 32'hFC00_0000); push_exp(SIG_PC, 4);
        check();

        phase = "illegal_funct";
        do_reset();
        mem_rdata = 32'h0000_003F;
        step();
        step();
        push_exp(SIG_STATE, 7); push_exp(SIG_ILL, 1);
        check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
